pckt_encoder: RTL and testbench

- Transmit-side counterpart of pckt_decoder_top. Accepts one message per beat (bytemask-qualified, up to OWIDTH bytes) and serialises a packet onto an IWIDTH-byte stream.
- Stream format: 2-byte message count, then for each message a 2-byte length followed by its payload. All fields are big-endian, first byte in the MSB lane. Packets carry sop/eop/per-byte empty.
- Drives pckt_decoder_top's input directly and honours its active-low ready.

---
 rtl/pckt_encoder.sv | 165 ++++++++++++++++
 tb/tb_pckt_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pckt_encoder.sv
// Packet encoder: turns bytemask-qualified message beats into a counted, length-prefixed,
// big-endian byte stream of IWIDTH-byte words with sop/eop/per-lane empty framing.
module pckt_encoder #(
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned OWIDTH = 16,
  parameter logic [15:0] MINLEN = 16'h8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [15:0]         in_count,
  input  logic [OWIDTH*8-1:0] in_data,
  input  logic [OWIDTH-1:0]   in_bytemask,
  output logic                out_valid,
  output logic                out_sop,
  output logic                out_eop,
  output logic [IWIDTH*8-1:0] out_data,
  output logic [IWIDTH-1:0]   out_empty,
  input  logic                out_ready_b,
  output logic                err_len,
  output logic                err_seq
);

  localparam int unsigned SBUF = 2 * IWIDTH + OWIDTH;
  localparam int unsigned FW   = $clog2(SBUF + 1);
  localparam logic [FW-1:0] IWF = FW'(IWIDTH);

  typedef enum logic [1:0] {StIdle, StPack, StFlush} state_e;

  state_e            state_q;
  logic [SBUF*8-1:0] sbuf_q;
  logic [FW-1:0]     fill_q;
  logic              sop_pend_q;
  logic [15:0]       msg_cnt_q;
  logic [15:0]       exp_cnt_q;

  logic                accept;
  logic                launch;
  logic                start;
  logic                drop;
  logic                contig;
  logic                seen_gap;
  logic                len_bad;
  logic                last_word;
  logic [7:0]          len;
  logic [FW-1:0]       nbytes;
  logic [15:0]         msg_cnt_nxt;
  logic [15:0]         exp_cnt_cur;
  logic [OWIDTH*8-1:0] payload;
  logic [SBUF*8-1:0]   chunk;
  logic [IWIDTH-1:0]   empty_nxt;

  assign in_ready = (state_q != StFlush) && (fill_q < IWF);
  assign accept   = in_valid && in_ready;
  assign start    = (state_q == StIdle) && in_first;
  assign drop     = (state_q == StIdle) && !in_first;

  // Outside FLUSH a launch needs a full word, which also keeps it exclusive with accept.
  assign launch    = !out_ready_b &&
                     ((fill_q >= IWF) || ((state_q == StFlush) && (fill_q != '0)));
  assign last_word = (state_q == StFlush) && (fill_q <= IWF);

  // Length, contiguity and the first-L-bytes payload of the offered beat
  always_comb begin
    len      = '0;
    contig   = 1'b1;
    seen_gap = 1'b0;
    for (int i = OWIDTH - 1; i >= 0; i--) begin
      if (in_bytemask[i]) begin
        len = len + 8'd1;
        if (seen_gap) contig = 1'b0;
      end else begin
        seen_gap = 1'b1;
      end
    end
  end

  always_comb begin
    payload = '0;
    for (int i = 0; i < OWIDTH; i++) begin
      if (8'(i) < len) payload[OWIDTH*8-1-8*i -: 8] = in_data[OWIDTH*8-1-8*i -: 8];
    end
  end

  always_comb begin
    if (start) begin
      chunk  = {in_count, 8'h00, len, payload, {((SBUF - 4 - OWIDTH) * 8){1'b0}}};
      nbytes = FW'(len) + FW'(4);
    end else begin
      chunk  = {8'h00, len, payload, {((SBUF - 2 - OWIDTH) * 8){1'b0}}};
      nbytes = FW'(len) + FW'(2);
    end
  end

  assign len_bad     = ({8'h00, len} < MINLEN) || !contig;
  assign msg_cnt_nxt = start ? 16'd1 : msg_cnt_q + 16'd1;
  assign exp_cnt_cur = start ? in_count : exp_cnt_q;

  // Unused low lanes of the final word; only meaningful while last_word holds
  always_comb begin
    empty_nxt = '0;
    for (int i = 0; i < IWIDTH; i++) begin
      empty_nxt[i] = last_word && (FW'(i) < (IWF - fill_q));
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      sbuf_q     <= '0;
      fill_q     <= '0;
      sop_pend_q <= 1'b0;
      msg_cnt_q  <= '0;
      exp_cnt_q  <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data   <= '0;
      out_empty  <= '0;
      err_len    <= 1'b0;
      err_seq    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_empty <= '0;
      err_len   <= 1'b0;
      err_seq   <= 1'b0;
      if (accept) begin
        if (drop) begin
          err_seq <= 1'b1;
        end else begin
          // Buffer bytes past fill are always zero, so OR-ing in the shifted chunk appends it
          sbuf_q    <= sbuf_q | (chunk >> {fill_q, 3'b000});
          fill_q    <= fill_q + nbytes;
          msg_cnt_q <= msg_cnt_nxt;
          err_len   <= len_bad;
          err_seq   <= (in_first && !start) || (in_last && (msg_cnt_nxt != exp_cnt_cur));
          if (start) begin
            sop_pend_q <= 1'b1;
            exp_cnt_q  <= in_count;
            state_q    <= in_last ? StFlush : StPack;
          end else if (in_last) begin
            state_q <= StFlush;
          end
        end
      end else if (launch) begin
        out_valid  <= 1'b1;
        out_sop    <= sop_pend_q;
        sop_pend_q <= 1'b0;
        out_data   <= sbuf_q[SBUF*8-1 -: IWIDTH*8];
        out_eop    <= last_word;
        out_empty  <= empty_nxt;
        sbuf_q     <= sbuf_q << (IWIDTH * 8);
        fill_q     <= (fill_q > IWF) ? (fill_q - IWF) : '0;
        if (last_word) state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_pckt_encoder.sv
// Bench for pckt_encoder: byte-queue reference model compared every cycle, plus directed
// literal checks of the example packets, backpressure, error pulses and mid-packet reset.
module tb_pckt_encoder;

  localparam int IW = 8;
  localparam int OW = 16;
  localparam logic [15:0] MINL = 16'h8;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_first = 1'b0;
  logic           in_last = 1'b0;
  logic [15:0]    in_count = '0;
  logic [OW*8-1:0] in_data = '0;
  logic [OW-1:0]  in_bytemask = '0;
  logic           out_valid;
  logic           out_sop;
  logic           out_eop;
  logic [IW*8-1:0] out_data;
  logic [IW-1:0]  out_empty;
  logic           out_ready_b = 1'b0;
  logic           err_len;
  logic           err_seq;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pckt_encoder #(.IWIDTH(IW), .OWIDTH(OW), .MINLEN(MINL)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_last(in_last), .in_count(in_count), .in_data(in_data), .in_bytemask(in_bytemask),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_empty(out_empty), .out_ready_b(out_ready_b), .err_len(err_len), .err_seq(err_seq)
  );

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: pending bytes as a queue ----------------
  logic [7:0] mq[$];
  bit m_flush, m_inpkt, m_sop;
  int m_cnt, m_want;
  bit e_valid, e_sop, e_eop, e_len, e_seq, e_ready;
  logic [7:0]  e_empty;
  logic [63:0] e_data;

  task automatic model_step();
    bit rdy, lch;
    int l, rem;
    logic [OW-1:0] ones, lj;
    logic [7:0] b;
    rdy = !m_flush && (mq.size() < IW);
    lch = !out_ready_b && ((mq.size() >= IW) || (m_flush && mq.size() > 0));
    e_valid = 0; e_sop = 0; e_eop = 0; e_empty = '0; e_data = '0; e_len = 0; e_seq = 0;
    if (in_valid && rdy) begin
      if (!m_inpkt && !in_first) begin
        e_seq = 1;
      end else begin
        l = $countones(in_bytemask);
        ones = '1;
        lj = ~(ones >> l);
        e_len = (l < int'(MINL)) || (in_bytemask != lj);
        if (!m_inpkt) begin
          mq.push_back(in_count[15:8]);
          mq.push_back(in_count[7:0]);
          m_cnt = 0; m_want = int'(in_count); m_sop = 1; m_inpkt = 1;
        end else if (in_first) begin
          e_seq = 1;
        end
        mq.push_back(8'h00);
        mq.push_back(8'(l));
        for (int i = 0; i < l; i++) mq.push_back(in_data[OW*8-1-8*i -: 8]);
        m_cnt++;
        if (in_last) begin
          if (m_cnt != m_want) e_seq = 1;
          m_flush = 1;
        end
      end
    end else if (lch) begin
      rem = (mq.size() < IW) ? mq.size() : IW;
      e_valid = 1; e_sop = m_sop; m_sop = 0;
      for (int i = 0; i < IW; i++) begin
        b = 8'h00;
        if (i < rem) b = mq.pop_front();
        e_data = (e_data << 8) | 64'(b);
      end
      if (m_flush && mq.size() == 0) begin
        e_eop = 1;
        e_empty = 8'((1 << (IW - rem)) - 1);
        m_flush = 0; m_inpkt = 0;
      end
    end
    e_ready = !m_flush && (mq.size() < IW);
  endtask

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mq.delete();
      m_flush = 0; m_inpkt = 0; m_sop = 0; m_cnt = 0; m_want = 0;
      e_valid = 0; e_sop = 0; e_eop = 0; e_len = 0; e_seq = 0; e_empty = '0; e_data = '0;
      e_ready = 1;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare and word log ----------------
  always @(negedge clk) begin
    if (rstb && chk_en) begin
      chk("frame", {76'h0, out_valid, out_sop, out_eop, 1'b0} | {72'h0, 8'h0},
          {76'h0, e_valid, e_sop, e_eop, 1'b0});
      chk("empty", {72'h0, out_empty}, {72'h0, e_empty});
      if (e_valid) chk("data", {16'h0, out_data}, {16'h0, e_data});
      chk("errs", {78'h0, err_len, err_seq}, {78'h0, e_len, e_seq});
      chk("in_ready", {79'h0, in_ready}, {79'h0, e_ready});
    end
  end

  logic [73:0] wlog[$];
  int eop_cnt = 0;
  int seq_cnt = 0;
  int len_cnt = 0;

  always @(negedge clk) begin
    if (rstb) begin
      if (out_valid) wlog.push_back({out_sop, out_eop, out_empty, out_data});
      if (out_valid && out_eop) eop_cnt++;
      if (err_seq) seq_cnt++;
      if (err_len) len_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0: out_ready_b = 1'b0;
      1: out_ready_b = 1'b1;
      default: out_ready_b = ($urandom_range(0, 3) == 0);
    endcase
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [OW*8-1:0] mk(input logic [7:0] s, input int l);
    logic [OW*8-1:0] r;
    r = '0;
    for (int i = 0; i < l; i++) r[OW*8-1-8*i -: 8] = s + 8'(i);
    return r;
  endfunction

  function automatic logic [OW-1:0] msk(input int l);
    logic [OW-1:0] ones;
    ones = '1;
    return ~(ones >> l);
  endfunction

  task automatic send(input bit f, input bit l, input logic [15:0] c,
                      input logic [OW*8-1:0] d, input logic [OW-1:0] m);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1; in_first = f; in_last = l; in_count = c; in_data = d; in_bytemask = m;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", {79'h0, in_ready}, {79'h0, 1'b1});
    @(posedge clk);
    #1;
    in_valid = 0; in_first = 0; in_last = 0;
  endtask

  task automatic wait_eop();
    int s, n;
    s = eop_cnt;
    n = 0;
    while (eop_cnt == s && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("eop_bound", {79'h0, eop_cnt != s}, {79'h0, 1'b1});
  endtask

  task automatic chk_word(input string nm, input int idx, input logic [73:0] exp);
    logic [73:0] act;
    act = '0;
    if (idx < wlog.size()) act = wlog[idx];
    chk(nm, {6'h0, act}, {6'h0, exp});
  endtask

  task automatic send_t1_second();
    send(0, 1, 16'd2, mk(8'h11, 10), msk(10));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int s0, l0, n, cnt, l;
    bit f;
    logic [OW-1:0] m;
    logic [73:0] w;

    repeat (3) @(posedge clk);
    #1 rstb = 1;
    chk_en = 1;
    @(negedge clk);
    chk("reset_valid", {79'h0, out_valid}, 80'h0);
    chk("reset_ready", {79'h0, in_ready}, {79'h0, 1'b1});
    chk("reset_errs", {78'h0, err_len, err_seq}, 80'h0);

    // Test 1: two messages, free-flowing output
    wlog.delete(); s0 = seq_cnt; l0 = len_cnt;
    send(1, 0, 16'd2, mk(8'h01, 8), msk(8));
    send_t1_second();
    wait_eop();
    chk("t1_words", {48'h0, 32'(wlog.size())}, {48'h0, 32'd3});
    chk_word("t1_w0", 0, {1'b1, 1'b0, 8'h00, 64'h0002_0008_0102_0304});
    chk_word("t1_w1", 1, {1'b0, 1'b0, 8'h00, 64'h0506_0708_000a_1112});
    chk_word("t1_w2", 2, {1'b0, 1'b1, 8'h00, 64'h1314_1516_1718_191a});
    chk("t1_noerr", {48'h0, 32'(seq_cnt - s0 + len_cnt - l0)}, 80'h0);

    // Test 2: single short-ish message with partial final word
    wlog.delete();
    send(1, 1, 16'd1, mk(8'h01, 9), msk(9));
    wait_eop();
    chk_word("t2_w0", 0, {1'b1, 1'b0, 8'h00, 64'h0001_0009_0102_0304});
    chk_word("t2_w1", 1, {1'b0, 1'b1, 8'h07, 64'h0506_0708_0900_0000});

    // Test 3: downstream stalled for 5 cycles mid-packet
    wlog.delete();
    bp_mode = 1;
    send(1, 0, 16'd2, mk(8'h01, 8), msk(8));
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_valid", {79'h0, out_valid}, 80'h0);
      chk("t3_stall_ready", {79'h0, in_ready}, 80'h0);
    end
    bp_mode = 0;
    send_t1_second();
    wait_eop();
    chk_word("t3_w0", 0, {1'b1, 1'b0, 8'h00, 64'h0002_0008_0102_0304});
    chk_word("t3_w1", 1, {1'b0, 1'b0, 8'h00, 64'h0506_0708_000a_1112});
    chk_word("t3_w2", 2, {1'b0, 1'b1, 8'h00, 64'h1314_1516_1718_191a});

    // Test 4: message count mismatch
    s0 = seq_cnt;
    send(1, 0, 16'd3, mk(8'h20, 8), msk(8));
    send(0, 1, 16'd3, mk(8'h30, 8), msk(8));
    wait_eop();
    @(negedge clk);
    chk("t4_seq_pulses", {48'h0, 32'(seq_cnt - s0)}, {48'h0, 32'd1});
    chk("t4_idle_ready", {79'h0, in_ready}, {79'h0, 1'b1});

    // Test 5: short and non-contiguous masks
    wlog.delete(); l0 = len_cnt;
    send(1, 0, 16'd2, 128'hA1A2A3A4_5555_5555_5555_5555_5555_5555, 16'hF000);
    send(0, 1, 16'd2, 128'hB1B2B3B4_B5B6B7B8_C1C2C3C4_C5C6C7C8, 16'hF0F0);
    wait_eop();
    chk("t5_len_pulses", {48'h0, 32'(len_cnt - l0)}, {48'h0, 32'd2});
    w = (wlog.size() > 0) ? wlog[0] : '0;
    chk("t5_len_a", {64'h0, w[47:32]}, {64'h0, 16'h0004});
    w = (wlog.size() > 1) ? wlog[1] : '0;
    chk("t5_len_b", {64'h0, w[63:48]}, {64'h0, 16'h0008});

    // Test 6: reset after the first word of test 1, then test 2 again
    wlog.delete();
    send(1, 0, 16'd2, mk(8'h01, 8), msk(8));
    n = 0;
    while (wlog.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rstb = 0;
    #1;
    chk("t6_rst_out", {out_valid, out_sop, out_eop, out_empty, out_data, err_len, err_seq},
        80'h0);
    #1 rstb = 1;
    wlog.delete();
    send(1, 1, 16'd1, mk(8'h01, 9), msk(9));
    wait_eop();
    chk("t6_words", {48'h0, 32'(wlog.size())}, {48'h0, 32'd2});
    chk_word("t6_w0", 0, {1'b1, 1'b0, 8'h00, 64'h0001_0009_0102_0304});
    chk_word("t6_w1", 1, {1'b0, 1'b1, 8'h07, 64'h0506_0708_0900_0000});

    // Random packets with random backpressure, checked by the model every cycle
    bp_mode = 2;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 9) == 0) send(0, 0, 16'd0, mk(8'hEE, 4), msk(4));
      n = $urandom_range(1, 4);
      cnt = ($urandom_range(0, 7) == 0) ? n + 1 : n;
      for (int k = 0; k < n; k++) begin
        f = (k == 0) || ($urandom_range(0, 9) == 0);
        l = $urandom_range(0, OW);
        m = ($urandom_range(0, 7) == 0) ? OW'($urandom) : msk(l);
        send(f, k == n - 1, 16'(cnt), {$urandom, $urandom, $urandom, $urandom}, m);
      end
      wait_eop();
    end
    bp_mode = 0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
